// File: rtl/stopwatch_bcd.sv
// rtl/stopwatch_bcd.sv - four-digit BCD event counter with start/stop/clear control
module stopwatch_bcd #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic        clk_10M,
    input  logic        reset,
    input  logic        clk_500K,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    output logic [15:0] bcd,
    output logic        running,
    output logic        ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

    state_t      state;
    state_t      state_next;
    logic        s0;
    logic        s1;
    logic        rise_edge;
    logic [15:0] prescaler;
    logic [16:0] bcd_next;

    // Returns {wrap_carry, incremented_value}; each digit rolls 9 -> 0 and carries.
    function automatic logic [16:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return {carry, r};
    endfunction

    assign rise_edge = s0 & ~s1;
    assign bcd_next  = bcd_inc(bcd);

    always_ff @(posedge clk_10M) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A lone stop outside RUN is swallowed rather than falling through to start.
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else if (stop) begin
            if (state == RUN) begin
                state_next = PAUSE;
            end
        end else if (start) begin
            if (state != RUN) begin
                state_next = RUN;
            end
        end
    end

    always_ff @(posedge clk_10M) begin
        if (reset) begin
            s0        <= 1'b0;
            s1        <= 1'b0;
            prescaler <= 16'd0;
            bcd       <= 16'h0000;
            running   <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            s0      <= clk_500K;
            s1      <= s0;
            running <= (state_next == RUN);
            ovf     <= 1'b0;
            if (clear) begin
                prescaler <= 16'd0;
                bcd       <= 16'h0000;
            end else if ((state == RUN) && rise_edge) begin
                // Uses the current state, so an edge alongside stop still counts.
                if (prescaler == PRESC_LAST) begin
                    prescaler <= 16'd0;
                    bcd       <= bcd_next[15:0];
                    ovf       <= bcd_next[16];
                end else begin
                    prescaler <= prescaler + 16'd1;
                end
            end
        end
    end

endmodule
